// File: rtl/rr_arb8_pkg.sv
// rr_arb8_pkg: shared types, sizes and the round-robin search for rr_arb8_sched
package rr_arb8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, BUSY} state_t;
  // Returns {found, idx}. The scan runs from the far end back towards start,
  // so the last hit kept is the first set bit at or after start (mod 8).
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] j;
    rr_pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = start + IDX_W'(i);
      if (req[j]) rr_pick = {1'b1, j};
    end
  endfunction
endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder with enable
//   idx : binary index
//   en  : output all-zero when low
//   y   : one-hot result
module dec3to8
  import rr_arb8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] y
);
  always_comb y = en ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/rr_arb8_sched.sv
// rr_arb8_sched: 8-way round-robin scheduler with hold limit and one-hot grant
//   clk, rst_n : clock, async active-low reset
//   req        : request lines, bit i = requester i
//   done       : owner finished (used only while a grant is active)
//   gnt        : one-hot grant, zero when idle
//   gnt_idx    : binary index of current (or last) owner
//   gnt_valid  : a grant is active
//   timeout    : 1-cycle pulse after a release forced by MAX_HOLD
module rr_arb8_sched
  import rr_arb8_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, idx_n;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic [IDX_W:0] pick;
  logic at_limit, rel, to_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt_idx  <= idx_n;
      hold_cnt <= cnt_n;
      timeout  <= to_n;
    end
  // While busy the search starts just past the owner, so a still-requesting
  // owner is reached last and wins only when nobody else is asking.
  always_comb begin
    at_limit = hold_cnt == CNT_W'(MAX_HOLD - 1);
    rel      = state == BUSY && (done || !req[gnt_idx] || at_limit);
    pick     = rr_pick(req, state == BUSY ? gnt_idx + 3'd1 : ptr);
    state_n  = state;
    ptr_n    = ptr;
    idx_n    = gnt_idx;
    cnt_n    = hold_cnt;
    to_n     = 1'b0;
    if (state == IDLE) begin
      if (pick[IDX_W]) begin
        state_n = BUSY;
        idx_n   = pick[IDX_W-1:0];
        cnt_n   = '0;
      end
    end else if (rel) begin
      ptr_n   = gnt_idx + 3'd1;
      to_n    = at_limit && !done && req[gnt_idx];
      state_n = pick[IDX_W] ? BUSY : IDLE;
      idx_n   = pick[IDX_W] ? pick[IDX_W-1:0] : gnt_idx;
      cnt_n   = '0;
    end else
      cnt_n = hold_cnt + 1'b1;
  end
  assign gnt_valid = state == BUSY;
  dec3to8 u_dec (.idx(gnt_idx), .en(gnt_valid), .y(gnt));
endmodule
